// File: rtl/fe_pkg.sv
// Shared front-end definitions for the RV32I multi-cycle core: control FSM
// encoding, opcode map, datapath mux select enums and timer sizing.
package fe_pkg;

    localparam int MEM_WAIT_CNT_WIDTH = 8;

    typedef logic [2:0] RV32I_CONTROL_UNIT_FSM_t;
    localparam RV32I_CONTROL_UNIT_FSM_t FETCH_S1     = 3'd0;
    localparam RV32I_CONTROL_UNIT_FSM_t DECODE_S2    = 3'd1;
    localparam RV32I_CONTROL_UNIT_FSM_t EXECUTE_S3   = 3'd2;
    localparam RV32I_CONTROL_UNIT_FSM_t MEM_S4       = 3'd3;
    localparam RV32I_CONTROL_UNIT_FSM_t WRITEBACK_S5 = 3'd4;
    localparam RV32I_CONTROL_UNIT_FSM_t HALT_S6      = 3'd5;

    typedef enum logic [6:0] {
        R_TYPE       = 7'b0110011,
        I_TYPE       = 7'b0010011,
        I_LOAD_TYPE  = 7'b0000011,
        S_TYPE       = 7'b0100011,
        B_TYPE       = 7'b1100011,
        J_JAL_TYPE   = 7'b1101111,
        I_JALR_TYPE  = 7'b1100111,
        U_LUI_TYPE   = 7'b0110111,
        U_AUIPC_TYPE = 7'b0010111,
        I_ENV_TYPE   = 7'b1110011
    } RV32I_OPCODE_t;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4 = 2'd0,
        PC_SRC_IMM   = 2'd1,
        PC_SRC_ALU   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_src_a_e;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            R_TYPE, I_TYPE, I_LOAD_TYPE, S_TYPE, B_TYPE, J_JAL_TYPE,
            I_JALR_TYPE, U_LUI_TYPE, U_AUIPC_TYPE, I_ENV_TYPE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_mem_wait_timer.sv
// Counts consecutive unacknowledged memory cycles; expired_o flags the cycle
// that would be the MEM_WAIT_MAX-th consecutive wait.
module rv32i_mem_wait_timer
    import fe_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [MEM_WAIT_CNT_WIDTH-1:0] LAST_WAIT = MEM_WAIT_CNT_WIDTH'(MEM_WAIT_MAX - 1);

    logic [MEM_WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// RV32I multi-cycle control FSM (FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT).
// Define RV32I_ENV_HALT_EN to make ECALL/EBREAK halt the core instead of NOP.
module rv32i_multicycle_ctrl
    import fe_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel_instr,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic [2:0] state,
    output logic       illegal,
    output logic       mem_err,
    output logic       halt
);

    RV32I_CONTROL_UNIT_FSM_t state_q, state_d;
    logic armed_q;
    logic illegal_q, illegal_d;
    logic mem_err_q, mem_err_d;
    logic wait_en, expired;
    logic [1:0] op_a_sel;
    logic op_b_sel;
    logic is_store;

    assign is_store = (opcode == S_TYPE);

    always_comb begin
        op_a_sel = ALU_A_RS1;
        op_b_sel = 1'b0;
        case (opcode)
            I_TYPE, I_LOAD_TYPE, S_TYPE, I_JALR_TYPE: op_b_sel = 1'b1;
            U_AUIPC_TYPE: begin
                op_a_sel = ALU_A_PC;
                op_b_sel = 1'b1;
            end
            U_LUI_TYPE: begin
                op_a_sel = ALU_A_ZERO;
                op_b_sel = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        mem_err_d     = mem_err_q;
        wait_en       = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_sel_instr = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = PC_SRC_PLUS4;
        rf_we         = 1'b0;
        wb_sel        = WB_SEL_ALU;
        alu_src_a     = ALU_A_RS1;
        alu_src_b     = 1'b0;
        halt          = 1'b0;
        case (state_q)
            FETCH_S1: begin
                // Fetch stays quiet for the first cycle after reset release.
                if (armed_q) begin
                    mem_req       = 1'b1;
                    mem_sel_instr = 1'b1;
                    wait_en       = !mem_ready;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        state_d = DECODE_S2;
                    end else if (expired) begin
                        mem_err_d = 1'b1;
                        state_d   = HALT_S6;
                    end
                end
            end
            DECODE_S2: begin
                if (is_legal_opcode(opcode)) begin
                    state_d = EXECUTE_S3;
                end else begin
                    illegal_d = 1'b1;
                    pc_we     = 1'b1;
                    state_d   = FETCH_S1;
                end
            end
            EXECUTE_S3: begin
                alu_src_a = op_a_sel;
                alu_src_b = op_b_sel;
                case (opcode)
                    I_LOAD_TYPE, S_TYPE: state_d = MEM_S4;
                    B_TYPE: begin
                        pc_we   = 1'b1;
                        pc_src  = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                        state_d = FETCH_S1;
                    end
                    I_ENV_TYPE: begin
`ifdef RV32I_ENV_HALT_EN
                        state_d = HALT_S6;
`else
                        pc_we   = 1'b1;
                        state_d = FETCH_S1;
`endif
                    end
                    default: state_d = WRITEBACK_S5;
                endcase
            end
            MEM_S4: begin
                // Operands stay selected so the ALU keeps presenting the address.
                alu_src_a = op_a_sel;
                alu_src_b = op_b_sel;
                mem_req   = 1'b1;
                mem_we    = is_store;
                wait_en   = !mem_ready;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = FETCH_S1;
                    end else begin
                        state_d = WRITEBACK_S5;
                    end
                end else if (expired) begin
                    mem_err_d = 1'b1;
                    state_d   = HALT_S6;
                end
            end
            WRITEBACK_S5: begin
                alu_src_a = op_a_sel;
                alu_src_b = op_b_sel;
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                state_d   = FETCH_S1;
                case (opcode)
                    I_LOAD_TYPE: wb_sel = WB_SEL_MEM;
                    J_JAL_TYPE: begin
                        wb_sel = WB_SEL_PC4;
                        pc_src = PC_SRC_IMM;
                    end
                    I_JALR_TYPE: begin
                        wb_sel = WB_SEL_PC4;
                        pc_src = PC_SRC_ALU;
                    end
                    default: ;
                endcase
            end
            HALT_S6: halt = 1'b1;
            default: state_d = FETCH_S1;
        endcase
    end

    rv32i_mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_d != state_q),
        .en_i     (wait_en),
        .expired_o(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_S1;
            armed_q   <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= 1'b1;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl: per-instruction vector table,
// randomized instruction stream against a class-level model, corner sequences.
module tb_rv32i_multicycle_ctrl;
    import fe_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_sel_instr, ir_we, pc_we, rf_we, alu_src_b;
    logic [1:0] pc_src, wb_sel, alu_src_a;
    logic [2:0] state;
    logic       illegal, mem_err, halt;

    int errors = 0;
    int checks = 0;
    bit exp_ill = 1'b0;

    rv32i_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel_instr(mem_sel_instr), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .rf_we(rf_we), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .state(state), .illegal(illegal), .mem_err(mem_err), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        bit         tk;
        int         fw;
        int         mw;
        int         cyc;
        logic [1:0] pcs;
        bit         rf;
        logic [1:0] wbs;
        bit         achk;
        logic [1:0] asa;
        bit         asb;
        bit         ill;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] outs();
        return {mem_req, mem_we, mem_sel_instr, ir_we, pc_we, pc_src, rf_we,
                wb_sel, alu_src_a, alu_src_b, illegal, mem_err, halt};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Instruction-class model: cycle cost and what the one pc/rf update looks like.
    function automatic vec_t model(input logic [6:0] op, input bit tk, input int fw, input int mw);
        vec_t v = '{op, tk, fw, mw, 0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
        case (op)
            7'b0110011: begin v.cyc = 4; v.rf = 1; v.achk = 1; end
            7'b0010011: begin v.cyc = 4; v.rf = 1; v.achk = 1; v.asb = 1; end
            7'b0000011: begin v.cyc = 5 + mw; v.rf = 1; v.wbs = 1; v.achk = 1; v.asb = 1; end
            7'b0100011: begin v.cyc = 4 + mw; v.achk = 1; v.asb = 1; end
            7'b1100011: begin v.cyc = 3; v.pcs = tk ? 2'd1 : 2'd0; v.achk = 1; end
            7'b1101111: begin v.cyc = 4; v.rf = 1; v.wbs = 2; v.pcs = 1; end
            7'b1100111: begin v.cyc = 4; v.rf = 1; v.wbs = 2; v.pcs = 2; v.achk = 1; v.asb = 1; end
            7'b0110111: begin v.cyc = 4; v.rf = 1; v.achk = 1; v.asa = 2; v.asb = 1; end
            7'b0010111: begin v.cyc = 4; v.rf = 1; v.achk = 1; v.asa = 1; v.asb = 1; end
            7'b1110011: begin v.cyc = 3; end
            default:    begin v.cyc = 2; v.ill = 1; end
        endcase
        v.cyc += fw;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        branch_taken = 1'b0;
        #2;
        chk("rst_state", int'(state), int'(FETCH_S1));
        chk("rst_outs", int'(outs()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_outs", int'(outs()), 0);
        @(posedge clk);
        #1;
        chk("armed_state", int'(state), int'(FETCH_S1));
        chk("armed_mem_req", int'(mem_req), 1);
        exp_ill = 1'b0;
    endtask

    // Entered and left at 1 time unit after a rising edge, in FETCH.
    task automatic run_instr(input string tag, input vec_t v);
        int cyc = 0, ir_cnt = 0, pc_cnt = 0, rf_cnt = 0, we_cnt = 0;
        int req_cnt = 0, ireq_cnt = 0, exe_cnt = 0, fcnt = 0, mcnt = 0;
        logic [1:0] g_pcs = 0, g_wbs = 0, g_a = 0;
        logic g_b = 0;
        bit done = 0;
        bit ls = (v.op == 7'b0000011) || (v.op == 7'b0100011);
        opcode = v.op;
        branch_taken = v.tk;
        while (!done && cyc < 60) begin
            if (mem_req && mem_sel_instr) begin
                mem_ready = (fcnt >= v.fw);
                fcnt++;
            end else if (mem_req) begin
                mem_ready = (mcnt >= v.mw);
                mcnt++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #3;
            cyc++;
            if (ir_we) ir_cnt++;
            if (mem_req) req_cnt++;
            if (mem_req && mem_sel_instr) ireq_cnt++;
            if (mem_we) we_cnt++;
            if (state == EXECUTE_S3) begin
                exe_cnt++;
                g_a = alu_src_a;
                g_b = alu_src_b;
            end
            if (rf_we) begin
                rf_cnt++;
                g_wbs = wb_sel;
            end
            if (pc_we) begin
                pc_cnt++;
                g_pcs = pc_src;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        exp_ill |= v.ill;
        chk({tag, "_finished"}, int'(done), 1);
        chk({tag, "_cycles"}, cyc, v.cyc);
        chk({tag, "_ir_we"}, ir_cnt, 1);
        chk({tag, "_pc_src"}, int'(g_pcs), int'(v.pcs));
        chk({tag, "_rf_we"}, rf_cnt, v.rf ? 1 : 0);
        if (v.rf) chk({tag, "_wb_sel"}, int'(g_wbs), int'(v.wbs));
        chk({tag, "_mem_we"}, we_cnt, (v.op == 7'b0100011) ? v.mw + 1 : 0);
        chk({tag, "_mem_req"}, req_cnt, v.fw + 1 + (ls ? v.mw + 1 : 0));
        chk({tag, "_ifetch"}, ireq_cnt, v.fw + 1);
        chk({tag, "_execute"}, exe_cnt, v.ill ? 0 : 1);
        if (v.achk) begin
            chk({tag, "_alu_a"}, int'(g_a), int'(v.asa));
            chk({tag, "_alu_b"}, int'(g_b), int'(v.asb));
        end
        chk({tag, "_illegal"}, int'(illegal), int'(exp_ill));
        chk({tag, "_next"}, int'(state), int'(FETCH_S1));
    endtask

    task automatic run_to_halt(input logic [6:0] op, input bit fetch_ok,
                               output int n, output int req_cnt, output int mem_cnt,
                               output int pc_cnt);
        n = 0; req_cnt = 0; mem_cnt = 0; pc_cnt = 0;
        opcode = op;
        while (state != HALT_S6 && n < 60) begin
            mem_ready = fetch_ok && mem_req && mem_sel_instr;
            #3;
            if (mem_req) req_cnt++;
            if (mem_req && !mem_sel_instr) mem_cnt++;
            if (pc_we) pc_cnt++;
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_halt(input string tag);
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk({tag, "_halt_state"}, int'(state), int'(HALT_S6));
            chk({tag, "_halt_quiet"}, int'({mem_req, mem_we, ir_we, pc_we, rf_we, halt}), 1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n, rq, mc, pc;
        logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                       7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                       7'b0010111, 7'b1110011};

        //            op           tk fw  mw  cyc pcs rf wbs achk asa asb ill
        tbl.push_back('{7'b0110011, 0, 0,  0,  4, 0, 1, 0, 1, 0, 0, 0}); // ADD
        tbl.push_back('{7'b0010011, 0, 1,  0,  5, 0, 1, 0, 1, 0, 1, 0}); // ADDI, fetch wait
        tbl.push_back('{7'b0000011, 0, 0,  3,  8, 0, 1, 1, 1, 0, 1, 0}); // LW, 3 mem waits
        tbl.push_back('{7'b0100011, 0, 0,  0,  4, 0, 0, 0, 1, 0, 1, 0}); // SW
        tbl.push_back('{7'b0100011, 0, 2,  1,  7, 0, 0, 0, 1, 0, 1, 0}); // SW with waits
        tbl.push_back('{7'b1100011, 1, 0,  0,  3, 1, 0, 0, 1, 0, 0, 0}); // BEQ taken
        tbl.push_back('{7'b1100011, 0, 0,  0,  3, 0, 0, 0, 1, 0, 0, 0}); // BEQ not taken
        tbl.push_back('{7'b0110111, 0, 0,  0,  4, 0, 1, 0, 1, 2, 1, 0}); // LUI
        tbl.push_back('{7'b0010111, 0, 2,  0,  6, 0, 1, 0, 1, 1, 1, 0}); // AUIPC
        tbl.push_back('{7'b1101111, 0, 0,  0,  4, 1, 1, 2, 0, 0, 0, 0}); // JAL
        tbl.push_back('{7'b1100111, 0, 1,  0,  5, 2, 1, 2, 1, 0, 1, 0}); // JALR
        tbl.push_back('{7'b1111111, 0, 0,  0,  2, 0, 0, 0, 0, 0, 0, 1}); // illegal
        tbl.push_back('{7'b0110011, 0, 14, 0, 18, 0, 1, 0, 1, 0, 0, 0}); // ready on last wait
        tbl.push_back('{7'b0000011, 0, 0, 14, 19, 0, 1, 1, 1, 0, 1, 0}); // ready on last wait
`ifndef RV32I_ENV_HALT_EN
        tbl.push_back('{7'b1110011, 0, 0,  0,  3, 0, 0, 0, 0, 0, 0, 0}); // ECALL as NOP
`endif

        do_reset();
        foreach (tbl[i]) run_instr($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 40; i++) begin
            logic [6:0] op;
            int r = $urandom_range(0, 11);
            if (r < 10) op = legal_ops[r];
            else if (r == 10) op = 7'b1111111;
            else op = 7'($urandom);
`ifdef RV32I_ENV_HALT_EN
            if (op == 7'b1110011) op = 7'b0110011;
`endif
            run_instr($sformatf("rnd%0d", i),
                      model(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3)));
        end

        do_reset();
        run_to_halt(7'b0110011, 1'b0, n, rq, mc, pc);
        chk("fetch_to_req_cycles", rq, 15);
        chk("fetch_to_mem_err", int'(mem_err), 1);
        chk("fetch_to_halt", int'(halt), 1);
        hold_halt("fetch_to");

        do_reset();
        chk("rst_clears_mem_err", int'(mem_err), 0);
        run_to_halt(7'b0000011, 1'b1, n, rq, mc, pc);
        chk("mem_to_mem_cycles", mc, 15);
        chk("mem_to_mem_err", int'(mem_err), 1);
        hold_halt("mem_to");

`ifdef RV32I_ENV_HALT_EN
        do_reset();
        run_to_halt(7'b1110011, 1'b1, n, rq, mc, pc);
        chk("ecall_cycles", n, 3);
        chk("ecall_pc_we", pc, 0);
        chk("ecall_mem_err", int'(mem_err), 0);
        hold_halt("ecall");
`endif

        do_reset();
        opcode = 7'b0100011;
        n = 0;
        while (!(mem_req && !mem_sel_instr) && n < 20) begin
            mem_ready = mem_req && mem_sel_instr;
            @(posedge clk);
            #1;
            n++;
        end
        mem_ready = 1'b0;
        #1;
        chk("sw_in_mem_we", int'(mem_we), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("sw_rst_req_drop", int'({mem_req, mem_we, pc_we}), 0);
        chk("sw_rst_state", int'(state), int'(FETCH_S1));
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
